rssb_core: RTL and testbench
============================

// Module: rssb_core
// PURPOSE
//  Parametrised word-wide successor of the 1-bit RSSB CPU: a one-instruction (Reverse Subtract, Skip if Borrow)
//  processor. Each instruction word is an operand address a: ACC <- M[a]-ACC; M[a] <- ACC; skip next word on borrow.
//  Single clock; instruction/data memory is external behind a req/ack port. Addresses 0..4 are core-mapped
//  registers/IO. Sits between program RAM and the system IO fabric.
// PARAMETERS
//  W         8   datapath/memory word width (W >= AW)
//  AW        8   address width; PC and operand addresses are AW bits, wrap mod 2**AW
//  RESET_PC  5   first instruction address after reset
//  HALT_ADDR 255 operand address that halts the core (only with RSSB_HALT_EN)
// PORTS
//  clk        in   1   sole clock, all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  ena        in   1   run enable; sampled only at instruction boundary (state FETCH)
//  mem_req    out  1   external access request; held high until mem_ack
//  mem_we     out  1   1 = write, 0 = read; stable while mem_req
//  mem_addr   out  AW  access address; stable while mem_req
//  mem_wdata  out  W   write data; stable while mem_req
//  mem_rdata  in   W   read data, valid in the mem_ack cycle
//  mem_ack    in   1   access complete this cycle
//  in_data    in   W   input word for address 3
//  in_valid   in   1   in_data valid
//  in_ready   out  1   1-cycle pulse: in_data consumed
//  out_data   out  W   last word written to address 4
//  out_valid  out  1   1-cycle pulse per write to address 4
//  flag       out  1   borrow of the last executed instruction
//  halted     out  1   core stopped (tied 0 without RSSB_HALT_EN)
// BEHAVIOUR
//  Reset: pc=RESET_PC, acc=0, state=FETCH, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0,
//   out_data=0, out_valid=0, flag=0, halted=0. Reset mid-access aborts it; mem_req low the cycle after rst.
//  FSM: FETCH -> LOAD -> EXEC -> (STORE) -> FETCH; HALT terminal (left only by rst).
//   FETCH: if ena=0 hold, mem_req=0. Else read M[pc]; on ack a <- mem_rdata[AW-1:0].
//   LOAD: m <- PC(0):pc | ACC(1):acc | ZERO(2):0 | IN(3):in_data, stall until in_valid, in_ready pulses on
//    consume | OUT(4):out_data | else external read M[a] (wait for ack).
//   EXEC: diff = {1'b0,m} - {1'b0,acc} (W+1 bits); borrow = diff[W]; r = diff[W-1:0]; acc <- r; flag <- borrow.
//    Next pc: a==0 -> pc <- r[AW-1:0] (no increment, skip ignored); else pc + (borrow ? 2 : 1) mod 2**AW.
//    Write-back of r: 0 via pc rule; 1 acc only; 2 dropped; 3 dropped; 4 out_data<-r, out_valid pulse; else STORE.
//   STORE: external write M[a]=r, hold until ack.
//  Handshake: one outstanding access; mem_req may assert combinationally-free (registered), ack in the same cycle
//   as req is legal (1-cycle access). ack while mem_req=0 is ignored.
//  Minimum latency: 3 cycles register operand, 4 cycles external operand, +wait states per ack delay.
//  ena dropped mid-instruction: current instruction completes; core parks in FETCH.
// CONFIGURATION
//  RSSB_HALT_EN defined: operand a==HALT_ADDR in LOAD enters HALT, no memory access, halted=1, mem_req=0,
//   pc/acc frozen. Undefined: HALT_ADDR is an ordinary external address; halted tied 0.
// STRUCTURE
//  rssb_pkg: state_t enum {FETCH,LOAD,EXEC,STORE,HALT}; constants ADDR_PC=0, ADDR_ACC=1, ADDR_ZERO=2,
//   ADDR_IN=3, ADDR_OUT=4.
//  Sub-module rssb_alu #(W): (m, acc) -> (r, borrow), purely combinational.
// TESTING
//  W=8: acc=0, M[10]=7, exec a=10 -> acc=7, M[10]=7, flag=0, pc+1.
//  acc=9, M[10]=3 -> acc=250, M[10]=250, flag=1, pc+2 (skip); pc=255 with skip wraps to 1.
//  a=2 (ZERO), acc=5 -> acc=251, flag=1; a=1 (ACC) -> acc=0, flag=0, no external write.
//  a=3 with in_valid low 4 cycles then in_data=20 -> stall, in_ready 1 pulse, acc=20-acc_old.
//  a=4, acc=0, out_data=6 -> out_valid 1 pulse, out_data=6; ack delayed 3 cycles -> addr/we/wdata stable.
//  rst during STORE wait -> mem_req 0 next cycle, pc=RESET_PC; RSSB_HALT_EN a=255 -> halted=1, no req.

Source files
------------

// File: rtl/rssb_pkg.sv
// Shared types and core-mapped address map for the RSSB word-wide core.
package rssb_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    LOAD  = 3'd1,
    EXEC  = 3'd2,
    STORE = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam int ADDR_PC   = 0;
  localparam int ADDR_ACC  = 1;
  localparam int ADDR_ZERO = 2;
  localparam int ADDR_IN   = 3;
  localparam int ADDR_OUT  = 4;

endpackage

// File: rtl/rssb_alu.sv
// Reverse subtract: r = m - acc, borrow set when acc > m.
module rssb_alu #(
  parameter int W = 8
) (
  input  logic [W-1:0] m,
  input  logic [W-1:0] acc,
  output logic [W-1:0] r,
  output logic         borrow
);

  logic [W:0] diff;

  assign diff   = {1'b0, m} - {1'b0, acc};
  assign r      = diff[W-1:0];
  assign borrow = diff[W];

endmodule

// File: rtl/rssb_core.sv
// One-instruction RSSB processor with external req/ack memory and core-mapped registers 0..4.
// Optional halt on operand HALT_ADDR is enabled with the RSSB_HALT_EN macro.
module rssb_core
  import rssb_pkg::*;
#(
  parameter int W         = 8,
  parameter int AW        = 8,
  parameter int RESET_PC  = 5,
  parameter int HALT_ADDR = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata,
  input  logic          mem_ack,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  output logic          flag,
  output logic          halted,
  output state_t        state_dbg
);

`ifdef RSSB_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  // Memory handshake: mem_req is registered and held with mem_we/mem_addr/mem_wdata
  // unchanged until a cycle with mem_ack=1; that cycle completes the access.
  // Input handshake: in_data is consumed in the cycle where in_valid && in_ready.

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [AW-1:0] a_q, a_d;
  logic [W-1:0]  m_q, m_d;
  logic          flag_q, flag_d;
  logic          halted_q, halted_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  logic [W-1:0]  alu_r;
  logic          alu_borrow;
  logic          acked;
  logic [AW-1:0] fetched;
  logic [AW-1:0] pc_exec;
  logic          sel_pc, sel_acc, sel_zero, sel_in, sel_out, sel_halt;

  function automatic logic is_halt(input logic [AW-1:0] addr);
    return HALT_EN && (addr == AW'(HALT_ADDR));
  endfunction

  function automatic logic is_ext(input logic [AW-1:0] addr);
    return (addr > AW'(ADDR_OUT)) && !is_halt(addr);
  endfunction

  rssb_alu #(.W(W)) u_alu (
    .m      (m_q),
    .acc    (acc_q),
    .r      (alu_r),
    .borrow (alu_borrow)
  );

  assign acked    = mem_req_q & mem_ack;
  assign fetched  = mem_rdata[AW-1:0];
  assign sel_halt = is_halt(a_q);
  assign sel_pc   = (a_q == AW'(ADDR_PC));
  assign sel_acc  = (a_q == AW'(ADDR_ACC));
  assign sel_zero = (a_q == AW'(ADDR_ZERO));
  assign sel_in   = (a_q == AW'(ADDR_IN));
  assign sel_out  = (a_q == AW'(ADDR_OUT));

  // A jump through address 0 replaces pc outright, so the skip is ignored there.
  assign pc_exec = sel_pc ? alu_r[AW-1:0]
                          : pc_q + (alu_borrow ? AW'(2) : AW'(1));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    a_d         = a_q;
    m_d         = m_q;
    flag_d      = flag_q;
    halted_d    = halted_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (mem_req_q) begin
          if (mem_ack) begin
            a_d     = fetched;
            state_d = LOAD;
            // Launch the operand read straight away to save a cycle.
            if (is_ext(fetched)) begin
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = fetched;
            end else begin
              mem_req_d = 1'b0;
            end
          end
        end else if (ena) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end
      end

      LOAD: begin
        if (sel_halt) begin
          state_d   = HALT;
          halted_d  = 1'b1;
          mem_req_d = 1'b0;
        end else if (sel_pc) begin
          m_d     = W'(pc_q);
          state_d = EXEC;
        end else if (sel_acc) begin
          m_d     = acc_q;
          state_d = EXEC;
        end else if (sel_zero) begin
          m_d     = '0;
          state_d = EXEC;
        end else if (sel_in) begin
          if (in_valid) begin
            m_d     = in_data;
            state_d = EXEC;
          end
        end else if (sel_out) begin
          m_d     = out_data_q;
          state_d = EXEC;
        end else if (acked) begin
          m_d       = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = EXEC;
        end
      end

      EXEC: begin
        acc_d  = alu_r;
        flag_d = alu_borrow;
        pc_d   = pc_exec;
        if (sel_out) begin
          out_data_d  = alu_r;
          out_valid_d = 1'b1;
        end
        if (is_ext(a_q)) begin
          state_d     = STORE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = a_q;
          mem_wdata_d = alu_r;
        end else begin
          state_d   = FETCH;
          mem_req_d = ena;
          mem_we_d  = 1'b0;
          if (ena) mem_addr_d = pc_exec;
        end
      end

      STORE: begin
        if (acked) begin
          state_d   = FETCH;
          mem_req_d = ena;
          mem_we_d  = 1'b0;
          if (ena) mem_addr_d = pc_q;
        end
      end

      HALT: begin
        mem_req_d = 1'b0;
      end

      default: begin
        state_d   = FETCH;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= AW'(RESET_PC);
      acc_q       <= '0;
      a_q         <= '0;
      m_q         <= '0;
      flag_q      <= 1'b0;
      halted_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      m_q         <= m_d;
      flag_q      <= flag_d;
      halted_q    <= halted_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == LOAD) && sel_in && !sel_halt && in_valid;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign flag      = flag_q;
  assign halted    = HALT_EN ? halted_q : 1'b0;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rssb_core.sv
// Directed bench for rssb_core: memory responder with variable ack delay and an event scoreboard.
module tb_rssb_core;
  import rssb_pkg::*;

  localparam int W    = 8;
  localparam int AW   = 8;
  localparam int EW   = 2 + AW + W;
  localparam int TRAP = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid, flag, halted;
  state_t        state_dbg;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs [1024];
  int            obs_cnt = 0;
  int            rd_idx = 0;
  bit            armed = 1'b0;

  logic [W-1:0]  mem [256];
  int            ack_delay = 0;
  int            wait_cnt = 0;
  int            stab_bad = 0;
  int            stab_seen = 0;
  logic [AW+W:0] cap = '0;

  rssb_core #(.W(W), .AW(AW), .RESET_PC(5), .HALT_ADDR(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .flag      (flag),
    .halted    (halted),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory responder and event monitor (writes and out pulses become observed events)
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
    if (out_valid && obs_cnt < 1024) begin
      obs[obs_cnt] = {1'b1, flag, {AW{1'b0}}, out_data};
      obs_cnt++;
    end
    if (mem_req) begin
      if (wait_cnt == 0) cap = {mem_we, mem_addr, mem_wdata};
      else if (cap !== {mem_we, mem_addr, mem_wdata}) stab_bad++;
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        if (wait_cnt > 0) stab_seen++;
        if (mem_we) begin
          if (obs_cnt < 1024) begin
            obs[obs_cnt] = {1'b0, flag, mem_addr, mem_wdata};
            obs_cnt++;
          end
        end else begin
          mem_rdata = mem[mem_addr];
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  function automatic logic [EW-1:0] ev(input bit is_out, input bit f,
                                       input logic [AW-1:0] a, input logic [W-1:0] d);
    return {is_out, f, a, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: pop one expected entry per observed event
  task automatic pump();
    logic [EW-1:0] e;
    while (rd_idx < obs_cnt) begin
      if (armed) begin
        if (exp_q.size() == 0) begin
          check("extra_event", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("event", 32'(obs[rd_idx]), 32'(e));
        end
      end
      rd_idx++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    pump();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ena      = 1'b0;
    in_valid = 1'b0;
    armed    = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = W'(TRAP);
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      cycle();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    ena   = 1'b0;
    armed = 1'b0;
    exp_q.delete();
    repeat (12) cycle();
  endtask

  initial begin
    int n, rdy, req_seen, sb0, ss0;

    // reset state
    repeat (2) cycle();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(FETCH));

    // A: subtract/skip, OUT, ACC, ZERO, IN stall; 1-cycle memory
    do_reset();
    fill_mem();
    mem[5] = 100; mem[6] = 101; mem[8] = 4; mem[10] = 1; mem[11] = 4;
    mem[12] = 2; mem[14] = 102; mem[16] = 3; mem[17] = 103;
    mem[100] = 9; mem[101] = 3; mem[102] = 0; mem[103] = 50;
    ack_delay = 0;
    exp_q.push_back(ev(1'b0, 1'b0, 8'd100, 8'd9));
    exp_q.push_back(ev(1'b0, 1'b1, 8'd101, 8'd250));
    exp_q.push_back(ev(1'b1, 1'b1, 8'd0, 8'd6));
    exp_q.push_back(ev(1'b1, 1'b0, 8'd0, 8'd6));
    exp_q.push_back(ev(1'b0, 1'b1, 8'd102, 8'd6));
    exp_q.push_back(ev(1'b0, 1'b0, 8'd103, 8'd36));
    rd_idx = obs_cnt;
    armed  = 1'b1;
    ena    = 1'b1;
    n = 0;
    while (exp_q.size() > 2 && n < 300) begin
      cycle();
      n++;
    end
    check("a_reach_in", 32'(exp_q.size()), 32'd2);
    rdy = 0;
    for (int i = 0; i < 8; i++) begin
      #1 if (in_ready) rdy++;
      cycle();
    end
    check("a_in_stall", 32'(rdy), 32'd0);
    in_data  = 8'd20;
    in_valid = 1'b1;
    rdy = 0;
    for (int i = 0; i < 8; i++) begin
      #1 if (in_ready) rdy++;
      cycle();
    end
    in_valid = 1'b0;
    check("a_in_ready_pulses", 32'(rdy), 32'd1);
    drain("a_drain", 300);

    // B: jump via address 0 to 255, skip wraps pc to 1; 3-cycle ack delay
    do_reset();
    fill_mem();
    mem[5] = 100; mem[6] = 0; mem[255] = 101; mem[1] = 102;
    mem[100] = 7; mem[101] = 3; mem[102] = 10;
    ack_delay = 3;
    sb0 = stab_bad;
    ss0 = stab_seen;
    exp_q.push_back(ev(1'b0, 1'b0, 8'd100, 8'd7));
    exp_q.push_back(ev(1'b0, 1'b1, 8'd101, 8'd4));
    exp_q.push_back(ev(1'b0, 1'b0, 8'd102, 8'd6));
    rd_idx = obs_cnt;
    armed  = 1'b1;
    ena    = 1'b1;
    drain("b_drain", 600);
    check("b_stable_req", 32'(stab_bad - sb0), 32'd0);
    check("b_waited_acks", 32'(stab_seen - ss0 >= 9), 32'd1);
    check("b_halted", 32'(halted), 32'd0);

    // C: reset while a store waits for ack
    do_reset();
    fill_mem();
    mem[5] = 100; mem[100] = 1;
    ack_delay = 20;
    ena = 1'b1;
    n = 0;
    while (!(mem_req && mem_we) && n < 150) begin
      cycle();
      n++;
    end
    check("c_store_req", 32'(mem_req && mem_we), 32'd1);
    repeat (2) cycle();
    check("c_store_addr", 32'(mem_addr), 32'd100);
    check("c_store_wdata", 32'(mem_wdata), 32'd1);
    rst = 1'b1;
    ena = 1'b0;
    cycle();
    check("c_abort_req", 32'(mem_req), 32'd0);
    check("c_abort_we", 32'(mem_we), 32'd0);
    check("c_abort_state", 32'(state_dbg), 32'(FETCH));
    rst = 1'b0;
    req_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (mem_req) req_seen++;
    end
    check("c_ena_low_idle", 32'(req_seen), 32'd0);
    ack_delay = 0;
    ena = 1'b1;
    n = 0;
    while (!mem_req && n < 10) begin
      cycle();
      n++;
    end
    check("c_restart_addr", 32'(mem_addr), 32'd5);
    check("c_restart_we", 32'(mem_we), 32'd0);
    ena = 1'b0;
    repeat (12) cycle();

`ifdef RSSB_HALT_EN
    // D: operand 255 halts without touching memory
    do_reset();
    fill_mem();
    mem[5] = 255;
    ena = 1'b1;
    repeat (10) cycle();
    check("d_halted", 32'(halted), 32'd1);
    check("d_no_req", 32'(mem_req), 32'd0);
    check("d_state", 32'(state_dbg), 32'(HALT));
    ena = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
